// File: rtl/elevator_ctrl_n_if.sv
// elevator_ctrl_n_if: call/request inputs and car status outputs of the elevator controller.
// master drives hall/car buttons and observes status; slave is the controller side.
interface elevator_ctrl_n_if #(
    parameter int FLOORS = 8,
    parameter int FLR_W  = 3
);
    logic [FLOORS-1:0] call_up;
    logic [FLOORS-1:0] call_dn;
    logic [FLOORS-1:0] car_req;
    logic [1:0]        dout;
    logic [FLR_W-1:0]  floor;
    logic              door_open;
    logic [FLOORS-1:0] pend_up;
    logic [FLOORS-1:0] pend_dn;
    logic [FLOORS-1:0] pend_car;

    modport master (
        output call_up, call_dn, car_req,
        input  dout, floor, door_open,
        input  pend_up, pend_dn, pend_car
    );

    modport slave (
        input  call_up, call_dn, car_req,
        output dout, floor, door_open,
        output pend_up, pend_dn, pend_car
    );
endinterface

// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor collective (SCAN) elevator controller.
// Ports: clk, rst_n (async low); bus.slave carries call_up/call_dn/car_req in,
// dout (UP=00 DOWN=01 STAY=10), floor, door_open, pend_up/pend_dn/pend_car out.
module elevator_ctrl_n #(
    parameter int FLOORS     = 8,
    parameter int FLR_W      = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    elevator_ctrl_n_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MOVE = 2'd1;
    localparam logic [1:0] S_DOOR = 2'd2;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] T_TRAVEL = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] T_DOOR   = TW'(DOOR_CYC - 1);

    // No UP call from the top floor, no DOWN call from the bottom floor.
    localparam logic [FLOORS-1:0] UP_MASK = ~(FLOORS'(1) << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DN_MASK = ~FLOORS'(1);

    logic [1:0]        state, state_nx;
    logic              dir, dir_nx;
    logic [FLR_W-1:0]  floor_q, floor_nx;
    logic [TW-1:0]     timer, timer_nx;
    logic [FLOORS-1:0] pend_up_q, pend_dn_q, pend_car_q;

    logic [FLOORS-1:0] up_in, dn_in, car_in, here;
    logic [FLOORS-1:0] clr_up, clr_dn, clr_car;
    logic [FLOORS-1:0] f_oh, nf_oh, hall_dir, in_dir;
    logic [FLR_W-1:0]  next_f;
    logic              ahead_f, behind_f, ahead_nf, stop, absorb;

    function automatic logic any_beyond(
        input logic [FLOORS-1:0] h,
        input logic [FLR_W-1:0]  f,
        input logic              d
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (d == DIR_UP && i > int'(f)) r = r | h[i];
            if (d == DIR_DN && i < int'(f)) r = r | h[i];
        end
        return r;
    endfunction

    always_comb begin
        up_in    = bus.call_up & UP_MASK;
        dn_in    = bus.call_dn & DN_MASK;
        car_in   = bus.car_req;
        here     = pend_up_q | pend_dn_q | pend_car_q;
        f_oh     = FLOORS'(1) << floor_q;
        next_f   = (dir == DIR_UP) ? floor_q + FLR_W'(1)
                                   : floor_q - FLR_W'(1);
        nf_oh    = FLOORS'(1) << next_f;
        hall_dir = (dir == DIR_UP) ? pend_up_q : pend_dn_q;
        in_dir   = (dir == DIR_UP) ? up_in : dn_in;
        ahead_f  = any_beyond(here, floor_q, dir);
        behind_f = any_beyond(here, floor_q, ~dir);
        // next_f may wrap while not moving; only consumed in MOVE.
        ahead_nf = any_beyond(here, next_f, dir);
        stop     = |(pend_car_q & nf_oh) | |(hall_dir & nf_oh)
                 | (~ahead_nf & |(here & nf_oh));
        absorb   = |((car_in | in_dir) & f_oh);
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        floor_nx = floor_q;
        timer_nx = timer;
        clr_up   = '0;
        clr_dn   = '0;
        clr_car  = '0;
        case (state)
            S_IDLE: begin
                if (|(here & f_oh)) begin
                    clr_up   = f_oh;
                    clr_dn   = f_oh;
                    clr_car  = f_oh;
                    state_nx = S_DOOR;
                    timer_nx = T_DOOR;
                end else if (any_beyond(here, floor_q, DIR_UP)) begin
                    dir_nx   = DIR_UP;
                    state_nx = S_MOVE;
                    timer_nx = T_TRAVEL;
                end else if (any_beyond(here, floor_q, DIR_DN)) begin
                    dir_nx   = DIR_DN;
                    state_nx = S_MOVE;
                    timer_nx = T_TRAVEL;
                end
            end
            S_MOVE: begin
                if (timer != '0) begin
                    timer_nx = timer - TW'(1);
                end else begin
                    floor_nx = next_f;
                    if (stop) begin
                        clr_car = nf_oh;
                        if (dir == DIR_UP) clr_up = nf_oh;
                        else               clr_dn = nf_oh;
                        // Last stop this sweep: serve both hall calls, turn round.
                        if (!ahead_nf) begin
                            clr_up = nf_oh;
                            clr_dn = nf_oh;
                            dir_nx = ~dir;
                        end
                        state_nx = S_DOOR;
                        timer_nx = T_DOOR;
                    end else if (ahead_nf) begin
                        timer_nx = T_TRAVEL;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                // Presses at the open floor are swallowed and hold the door.
                clr_car = f_oh;
                if (dir == DIR_UP) clr_up = f_oh;
                else               clr_dn = f_oh;
                if (absorb) begin
                    timer_nx = T_DOOR;
                end else if (timer != '0) begin
                    timer_nx = timer - TW'(1);
                end else if (ahead_f) begin
                    state_nx = S_MOVE;
                    timer_nx = T_TRAVEL;
                end else if (behind_f) begin
                    dir_nx   = ~dir;
                    state_nx = S_MOVE;
                    timer_nx = T_TRAVEL;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dir        <= DIR_UP;
            floor_q    <= '0;
            timer      <= '0;
            pend_up_q  <= '0;
            pend_dn_q  <= '0;
            pend_car_q <= '0;
        end else begin
            state      <= state_nx;
            dir        <= dir_nx;
            floor_q    <= floor_nx;
            timer      <= timer_nx;
            pend_up_q  <= (pend_up_q | up_in) & ~clr_up;
            pend_dn_q  <= (pend_dn_q | dn_in) & ~clr_dn;
            pend_car_q <= (pend_car_q | car_in) & ~clr_car;
        end
    end

    assign bus.dout      = (state == S_MOVE) ? {1'b0, dir} : 2'b10;
    assign bus.floor     = floor_q;
    assign bus.door_open = (state == S_DOOR);
    assign bus.pend_up   = pend_up_q;
    assign bus.pend_dn   = pend_dn_q;
    assign bus.pend_car  = pend_car_q;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: table vectors, directed corner cases and random
// stimulus against a floor/call-list reference model.
module tb_elevator_ctrl_n;
    localparam int F  = 8;
    localparam int FW = 3;
    localparam int TC = 4;
    localparam int DC = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elevator_ctrl_n_if #(.FLOORS(F), .FLR_W(FW)) bus ();

    elevator_ctrl_n #(
        .FLOORS(F), .FLR_W(FW), .TRAVEL_CYC(TC), .DOOR_CYC(DC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: car position, sweep direction (+1/-1), call lists.
    bit mu[F];
    bit md[F];
    bit mc[F];
    int m_floor  = 0;
    int m_dir    = 1;
    int m_left   = 0;
    bit m_moving = 0;
    bit m_door   = 0;

    function automatic bit want(input int f);
        return mc[f] | mu[f] | md[f];
    endfunction

    function automatic bit beyond(input int f, input int s);
        for (int g = f + s; g >= 0 && g < F; g += s)
            if (want(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < F; i++) begin
            mu[i] = 0; md[i] = 0; mc[i] = 0;
        end
        m_floor = 0; m_dir = 1; m_left = 0;
        m_moving = 0; m_door = 0;
    endfunction

    function automatic void model_step();
        bit iu[F], idn[F], ic[F], cu[F], cd[F], cc[F];
        int nf;
        bit fw;
        for (int i = 0; i < F; i++) begin
            iu[i]  = bus.call_up[i] && (i != F - 1);
            idn[i] = bus.call_dn[i] && (i != 0);
            ic[i]  = bus.car_req[i];
            cu[i] = 0; cd[i] = 0; cc[i] = 0;
        end
        if (!m_moving && !m_door) begin
            if (want(m_floor)) begin
                cu[m_floor] = 1; cd[m_floor] = 1; cc[m_floor] = 1;
                m_door = 1; m_left = DC;
            end else if (beyond(m_floor, 1)) begin
                m_dir = 1; m_moving = 1; m_left = TC;
            end else if (beyond(m_floor, -1)) begin
                m_dir = -1; m_moving = 1; m_left = TC;
            end
        end else if (m_moving) begin
            m_left--;
            if (m_left == 0) begin
                nf = m_floor + m_dir;
                fw = beyond(nf, m_dir);
                if (mc[nf] || (m_dir > 0 ? mu[nf] : md[nf]) || (!fw && want(nf))) begin
                    cc[nf] = 1;
                    if (m_dir > 0) cu[nf] = 1; else cd[nf] = 1;
                    if (!fw) begin
                        cu[nf] = 1; cd[nf] = 1; m_dir = -m_dir;
                    end
                    m_moving = 0; m_door = 1; m_left = DC;
                end else if (fw) begin
                    m_left = TC;
                end else begin
                    m_moving = 0;
                end
                m_floor = nf;
            end
        end else begin
            cc[m_floor] = 1;
            if (m_dir > 0) cu[m_floor] = 1; else cd[m_floor] = 1;
            if (ic[m_floor] || (m_dir > 0 ? iu[m_floor] : idn[m_floor])) begin
                m_left = DC;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_door = 0;
                    if (beyond(m_floor, m_dir)) begin
                        m_moving = 1; m_left = TC;
                    end else if (beyond(m_floor, -m_dir)) begin
                        m_dir = -m_dir; m_moving = 1; m_left = TC;
                    end
                end
            end
        end
        for (int i = 0; i < F; i++) begin
            mu[i] = (mu[i] | iu[i]) && !cu[i];
            md[i] = (md[i] | idn[i]) && !cd[i];
            mc[i] = (mc[i] | ic[i]) && !cc[i];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic logic [F-1:0] pk(input bit a[F]);
        logic [F-1:0] v;
        for (int i = 0; i < F; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_cmp();
        logic [29:0] act, exp;
        logic [1:0]  ed;
        ed  = m_moving ? (m_dir > 0 ? 2'b00 : 2'b01) : 2'b10;
        act = {bus.floor, bus.dout, bus.door_open,
               bus.pend_up, bus.pend_dn, bus.pend_car};
        exp = {FW'(m_floor), ed, m_door, pk(mu), pk(md), pk(mc)};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model t=%0t: got %h expected %h", $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic clr_in();
        bus.call_up = '0;
        bus.call_dn = '0;
        bus.car_req = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_rise(input string nm, input int maxc);
        logic prev;
        bit   ok;
        prev = bus.door_open;
        ok   = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            tick();
            if (!prev && bus.door_open) ok = 1;
            prev = bus.door_open;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: door did not open within %0d cycles", nm, maxc);
        end
    endtask

    task automatic wait_closed(input int maxc);
        for (int i = 0; i < maxc && bus.door_open; i++) tick();
    endtask

    typedef struct {
        int           pre;
        logic [F-1:0] req;
        logic [FW-1:0] f;
        logic [1:0]   d;
        logic         door;
        logic [F-1:0] pcar;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n;
        int kind;
        logic [F-1:0] bitv;

        tbl[0] = '{0,  8'h20, 3'd0, 2'b10, 1'b0, 8'h20};
        tbl[1] = '{0,  8'h00, 3'd0, 2'b00, 1'b0, 8'h20};
        tbl[2] = '{2,  8'h00, 3'd0, 2'b00, 1'b0, 8'h20};
        tbl[3] = '{0,  8'h00, 3'd1, 2'b00, 1'b0, 8'h20};
        tbl[4] = '{3,  8'h00, 3'd2, 2'b00, 1'b0, 8'h20};
        tbl[5] = '{11, 8'h00, 3'd5, 2'b10, 1'b1, 8'h00};
        tbl[6] = '{4,  8'h00, 3'd5, 2'b10, 1'b1, 8'h00};
        tbl[7] = '{0,  8'h00, 3'd5, 2'b10, 1'b0, 8'h00};

        clr_in();
        tick();
        check("rst_floor", 32'(bus.floor), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'h2);
        check("rst_door", 32'(bus.door_open), 32'd0);
        check("rst_pend", 32'({bus.pend_up, bus.pend_dn, bus.pend_car}), 32'd0);
        rst_n = 1'b1;

        // Trip 0 -> 5 on a single car request.
        for (int i = 0; i < 8; i++) begin
            repeat (tbl[i].pre) tick();
            bus.car_req = tbl[i].req;
            tick();
            clr_in();
            check($sformatf("s1_floor%0d", i), 32'(bus.floor), 32'(tbl[i].f));
            check($sformatf("s1_dout%0d", i), 32'(bus.dout), 32'(tbl[i].d));
            check($sformatf("s1_door%0d", i), 32'(bus.door_open), 32'(tbl[i].door));
            check($sformatf("s1_pcar%0d", i), 32'(bus.pend_car), 32'(tbl[i].pcar));
        end

        // Car stop at 3 on the way to a DOWN call at 6.
        do_reset();
        bus.call_dn = 8'h40;
        bus.car_req = 8'h08;
        tick();
        clr_in();
        wait_rise("s2_first", 60);
        check("s2_floor3", 32'(bus.floor), 32'd3);
        check("s2_dn_kept", 32'(bus.pend_dn), 32'h40);
        wait_rise("s2_second", 60);
        check("s2_floor6", 32'(bus.floor), 32'd6);
        check("s2_dn_clr", 32'(bus.pend_dn), 32'h0);

        // DOWN call at 4 is passed on the way up to 7.
        do_reset();
        bus.car_req = 8'h04;
        tick();
        clr_in();
        wait_rise("s3_at2", 40);
        check("s3_floor2", 32'(bus.floor), 32'd2);
        wait_closed(20);
        bus.car_req = 8'h80;
        tick();
        clr_in();
        bus.call_dn = 8'h10;
        tick();
        clr_in();
        check("s3_dout_up", 32'(bus.dout), 32'h0);
        wait_rise("s3_at7", 60);
        check("s3_floor7", 32'(bus.floor), 32'd7);
        check("s3_dn4_kept", 32'(bus.pend_dn), 32'h10);
        wait_rise("s3_at4", 60);
        check("s3_floor4", 32'(bus.floor), 32'd4);
        check("s3_dn4_clr", 32'(bus.pend_dn), 32'h0);

        // Dwell restart at 3; masked end-floor hall calls.
        do_reset();
        bus.car_req = 8'h08;
        tick();
        clr_in();
        wait_rise("s4_at3", 40);
        repeat (3) tick();
        bus.car_req = 8'h08;
        bus.call_up = 8'h80;
        bus.call_dn = 8'h01;
        tick();
        clr_in();
        check("s4_absorb", 32'({bus.pend_up, bus.pend_dn, bus.pend_car}), 32'd0);
        n = 0;
        while (bus.door_open && n < 20) begin
            n++;
            tick();
        end
        check("s4_dwell", 32'(n), 32'd6);
        repeat (2) tick();
        check("s4_stay", 32'(bus.dout), 32'h2);
        check("s4_floor", 32'(bus.floor), 32'd3);

        // Requests both ways from 3: UP is taken first.
        bus.car_req = 8'h42;
        tick();
        clr_in();
        tick();
        check("s5_dout_up", 32'(bus.dout), 32'h0);
        wait_rise("s5_at6", 60);
        check("s5_floor6", 32'(bus.floor), 32'd6);
        wait_rise("s5_at1", 80);
        check("s5_floor1", 32'(bus.floor), 32'd1);

        // Reset while travelling between 4 and 5.
        do_reset();
        bus.car_req = 8'h80;
        tick();
        clr_in();
        n = 0;
        while (bus.floor != 3'd4 && n < 60) begin
            n++;
            tick();
        end
        tick();
        check("s6_floor4", 32'(bus.floor), 32'd4);
        check("s6_moving", 32'(bus.dout), 32'h0);
        rst_n = 1'b0;
        #1;
        check("s6_rst_floor", 32'(bus.floor), 32'd0);
        check("s6_rst_dout", 32'(bus.dout), 32'h2);
        check("s6_rst_pend", 32'({bus.pend_up, bus.pend_dn, bus.pend_car}), 32'd0);
        tick();
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            clr_in();
            if (i == 1500) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 5) == 0) begin
                    kind = int'($urandom_range(0, 2));
                    bitv = F'(1) << $urandom_range(0, F - 1);
                    if (kind == 0)      bus.call_up = bitv;
                    else if (kind == 1) bus.call_dn = bitv;
                    else                bus.car_req = bitv;
                end
                tick();
            end
        end
        clr_in();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
